fft_stream_source: RTL and testbench
====================================

Name: fft_stream_source

Overview:
- AXI-Stream master and control sequencer that drives fft_core's input side: s_axis_* data plus i_point, i_inverse, i_start, i_burst and o_done.
- Holds one frame of complex samples in an internal buffer loaded by a simple write port.
- On command, it starts the core, streams the frame cfg_burst times back-to-back with tlast per frame, then waits for the core's done.
- Replaces bench-side stimulus in system integration and lets firmware run FFT jobs without a DMA.

Parameters:
DWIDTH, 32, sample width ({re,im} packed, matches fft_core)
MAX_POINT, 1024, buffer depth in samples
AW, 10, buffer address width, log2(MAX_POINT)
TIMEOUT, 65535, max cycles in WAIT_DONE before error

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cfg_point  in  11  one-hot FFT size, same encoding as fft_core i_point
cfg_inverse  in  1  inverse-FFT select
cfg_burst  in  10  frames per job, must be >=1
cmd_start  in  1  single-cycle job launch
busy  out  1  high from accepted cmd_start until done or error
done  out  1  one-cycle pulse at job completion
error  out  1  one-cycle pulse on rejected command or timeout
wr_collision  out  1  sticky flag: a write was attempted while busy; cleared on accepted cmd_start
wr_en  in  1  buffer write strobe
wr_addr  in  AW  buffer write address
wr_data  in  DWIDTH  buffer write data
fft_point  out  11  to fft_core i_point
fft_inverse  out  1  to fft_core i_inverse
fft_start  out  1  to fft_core i_start
fft_burst  out  10  to fft_core i_burst
fft_done  in  1  from fft_core o_done
m_axis_tdata  out  DWIDTH  to fft_core s_axis_tdata
m_axis_tvalid  out  1  to fft_core s_axis_tvalid
m_axis_tready  in  1  from fft_core s_axis_tready
m_axis_tlast  out  1  to fft_core s_axis_tlast

Behaviour:
- Reset values:
  - All outputs 0 and state IDLE.
  - Buffer RAM is not reset; its contents persist.
  - Reset mid-job aborts immediately: tvalid drops on the next edge and no done is produced.
- States:
  - IDLE -> START on a valid cmd_start.
  - START (1 cycle) -> STREAM.
  - STREAM -> WAIT_DONE after the final beat of frame cfg_burst.
  - WAIT_DONE -> IDLE on fft_done (done=1) or on timeout (error=1).
- Command validation (sampled in IDLE):
  - cfg_point must be one-hot with set bit in [4..10] (16..1024 points).
  - cfg_burst must be nonzero.
  - Otherwise: error pulse the next cycle and stay in IDLE.
  - cmd_start while busy is ignored, with no error.
- Config latching: accepted config is latched into fft_point/fft_inverse/fft_burst and held constant until return to IDLE. N = point count.
- Start timing:
  - Cycle 0: cmd_start sampled.
  - Cycle 1: fft_start=1 for exactly one cycle; buffer read of addr 0 issued.
  - Cycle 2: earliest tvalid=1 with buffer[0].
- Streaming:
  - Addresses 0..N-1, repeated per frame.
  - m_axis_tlast=1 on address N-1 of every frame.
  - Sustains 1 beat/cycle with tready held high, with no bubbles between frames.
- Handshake:
  - A beat transfers when tvalid && tready.
  - While tvalid && !tready, tdata, tlast and tvalid are held stable.
  - tvalid is never withdrawn without a transfer.
  - The buffer has 1-cycle synchronous read latency, so a 2-entry skid/prefetch register is required to meet full throughput under arbitrary tready.
- Counters:
  - Sample counter wraps N-1 -> 0 at each frame end.
  - Frame counter counts 1..cfg_burst.
  - After the last beat of the last frame, tvalid=0 on the next cycle.
- Done handling:
  - fft_done seen during START/STREAM is latched; done is then reported on the cycle after entry to WAIT_DONE.
  - Watchdog counts cycles in WAIT_DONE; reaching TIMEOUT gives error pulse and IDLE.
- Buffer writes:
  - Accepted only in IDLE.
  - wr_en while busy is dropped and sets wr_collision.
  - A write and a valid cmd_start in the same IDLE cycle: the write completes first, and streaming sees the new data.

Test Plan:
- Load ramp buffer[i]=i, cfg_point=0x400, burst=1, tready=1 -> fft_start at cycle 1; 1024 beats data 0..0x3FF on consecutive cycles; tlast only on beat 1023; done one cycle after fft_done.
- cfg_point=0x200, burst=3, tready=1 -> 1536 contiguous beats; tlast at beats 511, 1023, 1535; fft_burst=3 held for the whole job.
- N=16, tready toggling with pseudo-random 50% duty -> transferred sequence exactly 0..15; tdata/tlast stable whenever tvalid&&!tready (assertion); no duplicate or dropped beat.
- Invalid configs (cfg_point=0x008, 0x003, or burst=0) -> error pulse, busy stays 0, fft_start never asserted.
- wr_en during STREAM -> buffer unchanged on the next job, wr_collision=1 until the next accepted cmd_start; fft_done held low -> error after TIMEOUT cycles in WAIT_DONE.
- Assert reset at beat 100 of a 1024-point frame -> all outputs 0 after the edge; a subsequent cmd_start streams from address 0 with the preserved buffer contents.

Source files
------------

// File: rtl/fft_stream_source.sv
// fft_stream_source: frame buffer plus AXI-Stream master that sequences fft_core jobs.
// Firmware loads one frame through the write port and launches a job. The block
// pulses fft_start, streams the frame cfg_burst times with tlast per frame, then
// waits for fft_done or a watchdog timeout.
module fft_stream_source #(
    parameter int unsigned DWIDTH    = 32,
    parameter int unsigned MAX_POINT = 1024,
    parameter int unsigned AW        = 10,
    parameter int unsigned TIMEOUT   = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [10:0]       cfg_point,
    input  logic              cfg_inverse,
    input  logic [9:0]        cfg_burst,
    input  logic              cmd_start,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              wr_collision,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    output logic [10:0]       fft_point,
    output logic              fft_inverse,
    output logic              fft_start,
    output logic [9:0]        fft_burst,
    input  logic              fft_done,
    output logic [DWIDTH-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast
);

    typedef enum logic [1:0] {StIdle, StStart, StStream, StWaitDone} state_e;

    state_e state_q, state_d;

    // Latched job configuration
    logic [10:0] point_q;
    logic        inverse_q;
    logic [9:0]  burst_q;

    // Read side: address/frame counters feeding the synchronous RAM
    logic [AW-1:0] rd_addr_q;
    logic [9:0]    rd_frame_q;
    logic          rd_done_q;
    logic [AW:0]   last_addr;
    logic          rd_at_last;
    logic          issue;

    // RAM output stage plus 2-entry skid FIFO; together they hold at most two beats
    logic [DWIDTH-1:0] mem [MAX_POINT];
    logic [DWIDTH-1:0] ram_q;
    logic              ram_last_q;
    logic              rd_valid_q;
    logic [DWIDTH-1:0] fifo_data_q [2];
    logic [DWIDTH-1:0] fifo_data_d [2];
    logic              fifo_last_q [2];
    logic              fifo_last_d [2];
    logic [1:0]        fifo_cnt_q, fifo_cnt_d;
    logic [2:0]        occ;
    logic              push;

    // Output side
    logic [DWIDTH-1:0] head_data;
    logic              head_last;
    logic              pop;
    logic [9:0]        out_frame_q;
    logic              last_beat;

    // Control
    logic        cmd_ok;
    logic        accept;
    logic        done_seen_q;
    logic [31:0] wd_q;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        collision_q;

    assign cmd_ok = $onehot(cfg_point) && (|cfg_point[10:4]) && (cfg_burst != 10'd0);
    assign accept = (state_q == StIdle) && cmd_start && cmd_ok;

    assign last_addr  = (AW+1)'(point_q) - (AW+1)'(1);
    assign rd_at_last = ({1'b0, rd_addr_q} == last_addr);

    assign head_data = (fifo_cnt_q != 2'd0) ? fifo_data_q[0] : ram_q;
    assign head_last = (fifo_cnt_q != 2'd0) ? fifo_last_q[0] : ram_last_q;
    assign pop       = m_axis_tvalid && m_axis_tready;
    assign last_beat = pop && head_last && (out_frame_q == burst_q);

    // A read is issued only if its data will still fit once it lands next cycle
    assign occ   = {1'b0, fifo_cnt_q} + {2'b00, rd_valid_q};
    assign issue = (state_q == StStart) ||
                   ((state_q == StStream) && !rd_done_q && (occ < (3'd2 + {2'b00, pop})));

    // State register and registered status pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    // Next-state logic, command validation and job completion
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        error_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_start) begin
                    if (cmd_ok) state_d = StStart;
                    else        error_d = 1'b1;
                end
            end
            StStart:  state_d = StStream;
            StStream: if (last_beat) state_d = StWaitDone;
            StWaitDone: begin
                if (fft_done || done_seen_q) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (wd_q == TIMEOUT - 1) begin
                    error_d = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state and the datapath head
    always_comb begin
        busy          = (state_q != StIdle);
        fft_start     = (state_q == StStart);
        m_axis_tvalid = (state_q == StStream) && ((fifo_cnt_q != 2'd0) || rd_valid_q);
        m_axis_tdata  = m_axis_tvalid ? head_data : '0;
        m_axis_tlast  = m_axis_tvalid && head_last;
        fft_point     = point_q;
        fft_inverse   = inverse_q;
        fft_burst     = burst_q;
        done          = done_q;
        error         = error_q;
        wr_collision  = collision_q;
    end

    // Frame buffer: writes only while idle, 1-cycle synchronous read
    always_ff @(posedge clk) begin
        if (wr_en && (state_q == StIdle)) mem[wr_addr] <= wr_data;
        if (issue) ram_q <= mem[rd_addr_q];
    end

    // Config latch, read counters and output frame counter
    always_ff @(posedge clk) begin
        if (reset) begin
            point_q     <= '0;
            inverse_q   <= 1'b0;
            burst_q     <= '0;
            rd_addr_q   <= '0;
            rd_frame_q  <= '0;
            rd_done_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            ram_last_q  <= 1'b0;
            out_frame_q <= '0;
        end else begin
            rd_valid_q <= issue;
            if (issue) ram_last_q <= rd_at_last;
            if (accept) begin
                point_q     <= cfg_point;
                inverse_q   <= cfg_inverse;
                burst_q     <= cfg_burst;
                rd_addr_q   <= '0;
                rd_frame_q  <= 10'd1;
                rd_done_q   <= 1'b0;
                out_frame_q <= 10'd1;
            end else begin
                if (issue) begin
                    if (rd_at_last) begin
                        rd_addr_q <= '0;
                        if (rd_frame_q == burst_q) rd_done_q <= 1'b1;
                        else                       rd_frame_q <= rd_frame_q + 10'd1;
                    end else begin
                        rd_addr_q <= rd_addr_q + AW'(1);
                    end
                end
                if (pop && head_last && (out_frame_q != burst_q)) begin
                    out_frame_q <= out_frame_q + 10'd1;
                end
            end
        end
    end

    // Skid FIFO next state: pop the head, then append the landing RAM word
    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_last_d = fifo_last_q;
        fifo_cnt_d  = fifo_cnt_q;
        // A landing word consumed straight from the RAM register never enters the FIFO
        push = rd_valid_q && !((fifo_cnt_q == 2'd0) && pop);
        if (pop && (fifo_cnt_q != 2'd0)) begin
            fifo_data_d[0] = fifo_data_q[1];
            fifo_last_d[0] = fifo_last_q[1];
            fifo_cnt_d     = fifo_cnt_q - 2'd1;
        end
        if (push) begin
            fifo_data_d[fifo_cnt_d[0]] = ram_q;
            fifo_last_d[fifo_cnt_d[0]] = ram_last_q;
            fifo_cnt_d                 = fifo_cnt_d + 2'd1;
        end
    end

    // Skid FIFO registers
    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_cnt_q     <= '0;
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_last_q[0] <= 1'b0;
            fifo_last_q[1] <= 1'b0;
        end else begin
            fifo_cnt_q  <= fifo_cnt_d;
            fifo_data_q <= fifo_data_d;
            fifo_last_q <= fifo_last_d;
        end
    end

    // Early fft_done latch, WAIT_DONE watchdog and sticky write-collision flag
    always_ff @(posedge clk) begin
        if (reset) begin
            done_seen_q <= 1'b0;
            wd_q        <= '0;
            collision_q <= 1'b0;
        end else begin
            if (state_q == StIdle) begin
                done_seen_q <= 1'b0;
            end else if (fft_done && ((state_q == StStart) || (state_q == StStream))) begin
                done_seen_q <= 1'b1;
            end
            wd_q <= (state_q == StWaitDone) ? wd_q + 32'd1 : 32'd0;
            if (accept) begin
                collision_q <= 1'b0;
            end else if (wr_en && (state_q != StIdle)) begin
                collision_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fft_stream_source.sv
// Scoreboard bench for fft_stream_source: jobs push their expected beat sequence
// (built from a bench-side copy of the buffer) and a monitor compares transfers.
module tb_fft_stream_source;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int NMAX = 1024;
    localparam int TO = 300;

    logic          clk, reset;
    logic [10:0]   cfg_point;
    logic          cfg_inverse;
    logic [9:0]    cfg_burst;
    logic          cmd_start;
    logic          busy, done, error, wr_collision;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [10:0]   fft_point;
    logic          fft_inverse, fft_start;
    logic [9:0]    fft_burst;
    logic          fft_done;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;

    fft_stream_source #(.DWIDTH(DW), .MAX_POINT(NMAX), .AW(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .cfg_point(cfg_point), .cfg_inverse(cfg_inverse), .cfg_burst(cfg_burst),
        .cmd_start(cmd_start), .busy(busy), .done(done), .error(error),
        .wr_collision(wr_collision), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .fft_point(fft_point), .fft_inverse(fft_inverse), .fft_start(fft_start),
        .fft_burst(fft_burst), .fft_done(fft_done),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
    );

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] model_mem [NMAX];
    logic [DW:0]   exp_q [$];
    logic [9:0]    exp_burst = 10'd0;
    int            cyc = 0;
    int            n_beats = 0;
    int            first_cyc = -1;
    int            last_cyc = -1;
    bit            rdy_rand = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        m_axis_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: compares every transfer against the scoreboard and checks stall stability
    initial begin
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        logic          prev_last;
        logic [DW:0]   e;
        prev_stall = 0;
        prev_data  = '0;
        prev_last  = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    chk("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata},
                        {1'b1, prev_last, prev_data});
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL beat_unexpected: got 0x%0h with no beat expected",
                                 m_axis_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat", {m_axis_tlast, m_axis_tdata}, e);
                        chk("burst_held", fft_burst, exp_burst);
                        n_beats++;
                        last_cyc = cyc;
                        if (first_cyc < 0) first_cyc = cyc;
                    end
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_data  = m_axis_tdata;
                prev_last  = m_axis_tlast;
            end
        end
    end

    task automatic load(input int base, input int cnt, input bit rnd);
        for (int i = base; i < base + cnt; i++) begin
            @(posedge clk);
            #1;
            wr_en   = 1;
            wr_addr = AW'(i);
            wr_data = rnd ? DW'($urandom) : DW'(i);
            model_mem[i] = wr_data;
        end
        @(posedge clk);
        #1;
        wr_en = 0;
    endtask

    // Launch a job; the expected sequence is every frame of N buffer words, tlast on N-1
    task automatic start_job(input logic [10:0] pt, input logic inv, input logic [9:0] bu,
                             input bit do_wr, input int wa, input logic [DW-1:0] wd,
                             output int c0);
        int n;
        @(posedge clk);
        #1;
        cfg_point   = pt;
        cfg_inverse = inv;
        cfg_burst   = bu;
        cmd_start   = 1;
        if (do_wr) begin
            wr_en   = 1;
            wr_addr = AW'(wa);
            wr_data = wd;
            model_mem[wa] = wd;
        end
        c0        = cyc;
        first_cyc = -1;
        exp_burst = bu;
        n         = int'(pt);
        for (int f = 0; f < int'(bu); f++) begin
            for (int a = 0; a < n; a++) exp_q.push_back({a == n - 1, model_mem[a]});
        end
        @(posedge clk);
        #1;
        cmd_start = 0;
        wr_en     = 0;
        @(negedge clk);
        chk("start_pulse", fft_start, 1);
        chk("busy_on", busy, 1);
        chk("point_latched", fft_point, pt);
        chk("burst_latched", fft_burst, bu);
        chk("inverse_latched", fft_inverse, inv);
        chk("tvalid_cycle1", m_axis_tvalid, 0);
        chk("collision_cleared", wr_collision, 0);
        @(negedge clk);
        chk("start_one_cycle", fft_start, 0);
    endtask

    // Wait for the scoreboard to drain; optionally pulse fft_done or a write mid-stream.
    // Returns at cycle L+1 (L = cycle of the final beat), after its negedge checks.
    task automatic stream_end(input int done_at, input int coll_at);
        int base;
        bit ok;
        base = n_beats;
        ok   = 0;
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0) begin
                ok = 1;
                break;
            end
            #1;
            fft_done = (done_at >= 0) && (n_beats - base == done_at);
            wr_en    = (coll_at >= 0) && (n_beats - base == coll_at);
            wr_addr  = AW'(5);
            wr_data  = 32'hDEAD_BEEF;
        end
        #1;
        fft_done = 0;
        wr_en    = 0;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stream_timeout: %0d beats still pending", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        chk("tvalid_after_last", m_axis_tvalid, 0);
        chk("busy_in_wait", busy, 1);
        chk("done_not_yet", done, 0);
    endtask

    task automatic finish_done(input bit early);
        if (!early) begin
            @(posedge clk);
            #1;
            fft_done = 1;
            @(negedge clk);
            chk("done_before_fft_done", done, 0);
            @(posedge clk);
            #1;
            fft_done = 0;
        end
        @(negedge clk);
        chk("done_pulse", done, 1);
        chk("busy_off", busy, 0);
        @(negedge clk);
        chk("done_single", done, 0);
    endtask

    task automatic bad_job(input logic [10:0] pt, input logic [9:0] bu);
        @(posedge clk);
        #1;
        cfg_point = pt;
        cfg_burst = bu;
        cmd_start = 1;
        @(posedge clk);
        #1;
        cmd_start = 0;
        @(negedge clk);
        chk("bad_error", error, 1);
        chk("bad_busy", busy, 0);
        chk("bad_start", fft_start, 0);
        @(negedge clk);
        chk("bad_error_single", error, 0);
        chk("bad_start2", fft_start, 0);
    endtask

    initial begin
        int c0;
        int n;
        reset = 1;
        cfg_point = 0;
        cfg_inverse = 0;
        cfg_burst = 0;
        cmd_start = 0;
        wr_en = 0;
        wr_addr = 0;
        wr_data = 0;
        fft_done = 0;
        m_axis_tready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", {busy, done, error, wr_collision, fft_inverse, fft_start,
                            m_axis_tvalid, m_axis_tlast}, 0);
        chk("rst_point", fft_point, 0);
        chk("rst_burst", fft_burst, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        @(posedge clk);
        #1;
        reset = 0;

        // Ramp, 1024 points, one frame, full throughput
        load(0, NMAX, 0);
        start_job(11'h400, 0, 10'd1, 0, 0, '0, c0);
        stream_end(-1, -1);
        chk("a_first_latency", 64'(first_cyc - c0), 2);
        chk("a_contiguous", 64'(last_cyc - first_cyc), 1023);
        finish_done(0);

        // 512 points x3, fft_done arrives early and is reported after entry to WAIT_DONE
        start_job(11'h200, 1, 10'd3, 0, 0, '0, c0);
        stream_end(300, -1);
        chk("b_first_latency", 64'(first_cyc - c0), 2);
        chk("b_contiguous", 64'(last_cyc - first_cyc), 1535);
        finish_done(1);

        // Rejected commands
        bad_job(11'h008, 10'd1);
        bad_job(11'h003, 10'd1);
        bad_job(11'h400, 10'd0);

        // 16 points x2, random data and tready, write alongside cmd, collision, timeout
        load(0, 16, 1);
        rdy_rand = 1;
        start_job(11'h010, 1'($urandom_range(0, 1)), 10'd2, 1, 3, DW'($urandom), c0);
        stream_end(-1, 4);
        chk("collision_set", wr_collision, 1);
        n = 1;
        while (!error && n < TO + 10) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycles", 64'(n), 64'(TO + 1));
        chk("timeout_busy_off", busy, 0);
        chk("timeout_no_done", done, 0);
        chk("collision_sticky", wr_collision, 1);
        rdy_rand = 0;

        // Next job sees the unmodified buffer and clears the collision flag
        start_job(11'h010, 0, 10'd1, 0, 0, '0, c0);
        stream_end(-1, -1);
        finish_done(0);

        // Reset during beat 100 of a 1024-point frame
        start_job(11'h400, 0, 10'd1, 0, 0, '0, c0);
        n = n_beats;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            if (n_beats - n >= 100) break;
        end
        #1;
        reset = 1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_outputs", {busy, done, error, fft_start, m_axis_tvalid, m_axis_tlast}, 0);
        chk("midrst_point", fft_point, 0);
        chk("midrst_tdata", m_axis_tdata, 0);
        @(posedge clk);
        #1;
        reset = 0;
        exp_q.delete();
        start_job(11'h010, 0, 10'd1, 0, 0, '0, c0);
        stream_end(-1, -1);
        chk("d_first_latency", 64'(first_cyc - c0), 2);
        finish_done(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
